// File: rtl/leaf_response_collector_pkg.sv
// Shared types for the leaf response collector: source-tagged beat layout
// and the id-width helper used to size the source tag.
package leaf_collect_pkg;

  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int N_CHILD_DEF = 5;
  localparam int DATA_W_DEF  = 8;
  localparam int ID_W_DEF    = id_w(N_CHILD_DEF);

  typedef struct packed {
    logic [ID_W_DEF-1:0]   src;
    logic [DATA_W_DEF-1:0] data;
  } beat_t;

endpackage

// File: rtl/leaf_response_collector_if.sv
// Child-side fan-in channels plus the single merged output stream.
// The slave side is the collector; the master side drives children and sink.
interface leaf_response_collector_if #(
  parameter int N_CHILD = 5,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 3
);
  logic [N_CHILD-1:0]        in_valid;
  logic [N_CHILD*DATA_W-1:0] in_data;
  logic [N_CHILD-1:0]        in_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [ID_W-1:0]           out_src;
  logic                      out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/leaf_response_collector_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, searching modulo N.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
  parameter int N   = 5,
  parameter int IDW = 3
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/leaf_response_collector.sv
// Merges N_CHILD child response streams into one source-tagged stream
// through a round-robin arbiter and a small first-word-fall-through FIFO.
module leaf_response_collector
  import leaf_collect_pkg::*;
#(
  parameter int N_CHILD = N_CHILD_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  leaf_response_collector_if.slave bus,
  output logic [CNT_W-1:0]         accepted
);

  localparam int ID_W  = id_w(N_CHILD);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    g_idx;
  logic [ID_W-1:0]    rr_nxt;
  logic [N_CHILD-1:0] grant;
  logic               any_req;

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CW-1:0]      count;
  beat_t              mem [DEPTH];
  beat_t              wr_beat;
  beat_t              head;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  rr_arbiter #(
    .N   (N_CHILD),
    .IDW (ID_W)
  ) u_arb (
    .req   (bus.in_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (g_idx),
    .any   (any_req)
  );

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Readiness is gated only by FIFO fullness and reset, never by out_ready.
  assign bus.in_ready = (full || rst) ? '0 : grant;
  assign push         = any_req && !full && !rst;

  assign bus.out_valid = !empty && !rst;
  assign pop           = bus.out_valid && bus.out_ready;

  assign rr_nxt = (g_idx == ID_W'(N_CHILD - 1)) ? '0 : g_idx + 1'b1;

  always_comb begin
    wr_beat      = '0;
    wr_beat.src  = g_idx;
    wr_beat.data = bus.in_data[int'(g_idx)*DATA_W +: DATA_W];
  end

  assign head         = mem[rd_ptr];
  assign bus.out_data = head.data;
  assign bus.out_src  = head.src;

  // Storage carries no reset: only the pointers and count decide validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_beat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rr_ptr   <= '0;
      accepted <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        rr_ptr   <= rr_nxt;
        accepted <= accepted + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_ready_onehot : assert property (@(posedge clk) $onehot0(bus.in_ready));
  a_no_push_full : assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_pop_empty : assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: tb/tb_leaf_response_collector.sv
// Directed bench for the leaf response collector: reset, rotation, latency,
// full/back-pressure, counter wrap and mid-stream reset.
module tb_leaf_response_collector;

  logic        clk;
  logic        rst;
  logic [15:0] accepted;
  int          n_tests;
  int          n_fail;

  leaf_response_collector_if #(.N_CHILD(5), .DATA_W(8), .ID_W(3)) bus ();

  leaf_response_collector #(
    .N_CHILD (5),
    .DATA_W  (8),
    .DEPTH   (4),
    .CNT_W   (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .accepted (accepted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench still running at %0t, limit 100000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [7:0] d);
    bus.in_data[i*8 +: 8] = d;
  endtask

  logic [2:0] exp_src [4];
  logic [7:0] exp_dat [4];

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 5'h1F;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // 1: reset held with every child requesting
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_accepted", 32'(accepted), 32'h0);
    end
    rst = 1'b0;
    #1;

    // 2: rotation 0,1,2,3,4,0 with out_src trailing one cycle
    for (int i = 0; i < 6; i++) begin
      chk("rot_grant", 32'(bus.in_ready), 32'(5'b1 << (i % 5)));
      tick();
      chk("rot_out_valid", 32'(bus.out_valid), 32'h1);
      chk("rot_out_src", 32'(bus.out_src), 32'(i % 5));
    end
    chk("rot_accepted", 32'(accepted), 32'd6);
    bus.in_valid = '0;
    tick();
    chk("rot_drained", 32'(bus.out_valid), 32'h0);

    // 3: single child, one-cycle latency from an empty FIFO
    bus.out_ready = 1'b0;
    set_data(2, 8'hA5);
    bus.in_valid = 5'b00100;
    #1;
    chk("lat_grant", 32'(bus.in_ready), 32'h04);
    chk("lat_pre_valid", 32'(bus.out_valid), 32'h0);
    tick();
    bus.in_valid = '0;
    chk("lat_out_valid", 32'(bus.out_valid), 32'h1);
    chk("lat_out_data", 32'(bus.out_data), 32'hA5);
    chk("lat_out_src", 32'(bus.out_src), 32'h2);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("lat_popped", 32'(bus.out_valid), 32'h0);

    // 4: fill to DEPTH, single pop, refill, ordered drain
    for (int i = 0; i < 5; i++) set_data(i, 8'(8'h10 + i));
    bus.in_valid = 5'h1F;
    repeat (4) tick();
    chk("full_in_ready", 32'(bus.in_ready), 32'h0);
    chk("full_head_src", 32'(bus.out_src), 32'h3);
    chk("full_head_data", 32'(bus.out_data), 32'h13);
    chk("full_accepted", 32'(accepted), 32'd11);
    tick();
    chk("full_hold_ready", 32'(bus.in_ready), 32'h0);
    chk("full_hold_src", 32'(bus.out_src), 32'h3);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    #1;
    chk("pop1_head_src", 32'(bus.out_src), 32'h4);
    chk("pop1_head_data", 32'(bus.out_data), 32'h14);
    chk("pop1_in_ready", 32'(bus.in_ready), 32'h04);
    chk("pop1_accepted", 32'(accepted), 32'd11);
    tick();
    chk("refill_in_ready", 32'(bus.in_ready), 32'h0);
    chk("refill_accepted", 32'(accepted), 32'd12);
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    exp_src[0] = 3'd4; exp_dat[0] = 8'h14;
    exp_src[1] = 3'd0; exp_dat[1] = 8'h10;
    exp_src[2] = 3'd1; exp_dat[2] = 8'h11;
    exp_src[3] = 3'd2; exp_dat[3] = 8'h12;
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", 32'(bus.out_valid), 32'h1);
      chk("drain_src", 32'(bus.out_src), 32'(exp_src[k]));
      chk("drain_data", 32'(bus.out_data), 32'(exp_dat[k]));
      tick();
    end
    chk("drain_empty", 32'(bus.out_valid), 32'h0);

    // 5: counter wrap from 0xFFFF
    force dut.accepted = 16'hFFFF;
    #1;
    release dut.accepted;
    #1;
    chk("wrap_preload", 32'(accepted), 32'hFFFF);
    set_data(0, 8'h55);
    bus.in_valid = 5'b00001;
    tick();
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    chk("wrap_accepted", 32'(accepted), 32'h0);

    // 6: reset with three beats buffered
    set_data(1, 8'h21);
    set_data(2, 8'h22);
    bus.in_valid = 5'b00110;
    tick();
    tick();
    bus.in_valid = '0;
    chk("mid_pre_valid", 32'(bus.out_valid), 32'h1);
    chk("mid_pre_data", 32'(bus.out_data), 32'h55);
    chk("mid_pre_accepted", 32'(accepted), 32'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_post_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_post_accepted", 32'(accepted), 32'h0);
    chk("mid_post_rr_ptr", 32'(dut.rr_ptr), 32'h0);
    bus.out_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("mid_stays_empty", 32'(bus.out_valid), 32'h0);
    end
    set_data(1, 8'h77);
    bus.in_valid = 5'b00010;
    #1;
    chk("fresh_grant", 32'(bus.in_ready), 32'h02);
    tick();
    bus.in_valid = '0;
    chk("fresh_valid", 32'(bus.out_valid), 32'h1);
    chk("fresh_data", 32'(bus.out_data), 32'h77);
    chk("fresh_src", 32'(bus.out_src), 32'h1);
    tick();
    chk("fresh_popped", 32'(bus.out_valid), 32'h0);
    chk("fresh_accepted", 32'(accepted), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
